spi_fram_master: RTL
====================

SPI_FRAM_MASTER -- requirements
Module: spi_fram_master

Interface
REQ-001 Parameter CLK_DIV, default 2: sclk half-period in clk cycles; legal range 1..255.
REQ-002 Parameter CS_GAP, default 4: minimum n_ss-high cycles after each frame; legal range 1..255.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 req  input  1  transaction request; sampled only when busy=0.
REQ-006 we  input  1  1=write, 0=read; captured at accept.
REQ-007 addr  input  24  byte address; captured at accept and sent unmodified.
REQ-008 wdata  input  8  write byte; captured at accept.
REQ-009 rdata  output  8  read byte; valid from done until next accept.
REQ-010 busy  output  1  high from the cycle after accept until done.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 n_ss  output  1  SPI chip select, active-low.
REQ-013 sclk  output  1  SPI clock, mode 0 (idle low).
REQ-014 mosi  output  1  SPI data to FRAM, MSB first.
REQ-015 miso  input  1  SPI data from FRAM.

Function
REQ-016 Accept = req && !busy && !rst at edge T; inputs are latched at T; req while busy is ignored, with no queueing.
REQ-017 FSM states: IDLE, SHIFT, HOLD, GAP, DONE; a write runs SHIFT-HOLD-GAP twice (WREN frame, then WRITE frame), a read runs it once.
REQ-018 Read frame bytes: 0x03, addr[23:16], addr[15:8], addr[7:0], then 8 data clocks with mosi=0.
REQ-019 Write sequence: frame 1 = 0x06 only; frame 2 = 0x02, addr[23:16], addr[15:8], addr[7:0], wdata.
REQ-020 At T+1: n_ss=0, sclk=0, mosi = bit 7 of first byte.
REQ-021 Each bit lasts 2*CLK_DIV cycles: CLK_DIV cycles sclk=0 then CLK_DIV cycles sclk=1.
REQ-022 mosi changes only in the cycle sclk goes 1->0 (or at frame start) and is stable while sclk=1.
REQ-023 During read data bits, miso is sampled at the clk edge where sclk goes 0->1 and shifted MSB first into the read shift register.
REQ-024 HOLD: after the last bit, sclk=0 and n_ss=0 for CLK_DIV cycles; mosi holds the last value.
REQ-025 GAP: n_ss=1, sclk=0, mosi=0 for CS_GAP cycles.
REQ-026 Read timing: n_ss low for 81*CLK_DIV cycles; done=1 and busy=0 at T+1+81*CLK_DIV+CS_GAP.
REQ-027 Write timing: frame 1 n_ss low 17*CLK_DIV cycles, GAP, frame 2 n_ss low 81*CLK_DIV cycles, GAP; done at T+1+98*CLK_DIV+2*CS_GAP.
REQ-028 rdata updates only in the done cycle of a read; a write leaves rdata unchanged.
REQ-029 A new accept is allowed in the done cycle (req && !busy), giving back-to-back transactions separated by at least CS_GAP n_ss-high cycles.
REQ-030 Bit and byte counters wrap only at frame end; sclk never toggles while n_ss=1.

Reset
REQ-031 Reset values: n_ss=1, sclk=0, mosi=0, busy=0, done=0, rdata=0x00, FSM=IDLE.
REQ-032 rst asserted mid-frame aborts the transaction: on the next cycle n_ss=1 and sclk=0, with no done pulse; a partial write is not completed.
REQ-033 rst has priority over req in the same cycle.

Verification
REQ-034 Bench: CLK_DIV=2, CS_GAP=4, connected to a behavioral FRAM slave (mode 0, WREN-gated writes).
REQ-035 Write addr=0x000123, wdata=0xA5 -> bytes 06 | 02 00 01 23 A5 on mosi, done at T+205; slave memory[0x123]=0xA5.
REQ-036 Read addr=0x000123 after REQ-035 -> bytes 03 00 01 23 on mosi, rdata=0xA5 with done at T+167, busy high T+1..T+166.
REQ-037 req asserted again in the done cycle of a read -> n_ss high exactly CS_GAP cycles between frames, second transaction completes correctly.
REQ-038 rst pulsed during the address byte of a write -> n_ss=1 and sclk=0 the next cycle, no done; a subsequent read of that address returns the old value.
REQ-039 req pulsed while busy -> ignored, and the transaction count on the bus is unchanged; CLK_DIV=1 rerun of REQ-035/036 -> read done at T+86, write done at T+107.

Source files
------------

// File: rtl/spi_fram_master_if.sv
// Host request/response and SPI pin bundle for the FRAM master.
// The slave modport is the controller; the master modport is the host plus the FRAM device.
interface spi_fram_master_if;
    logic        req;
    logic        we;
    logic [23:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        busy;
    logic        done;
    logic        n_ss;
    logic        sclk;
    logic        mosi;
    logic        miso;

    modport master (
        output req, we, addr, wdata, miso,
        input  rdata, busy, done, n_ss, sclk, mosi
    );

    modport slave (
        input  req, we, addr, wdata, miso,
        output rdata, busy, done, n_ss, sclk, mosi
    );
endinterface

// File: rtl/spi_fram_master.sv
// SPI mode-0 master issuing single-byte FRAM READ, or WREN followed by WRITE.
// Every frame is SHIFT (bits), HOLD (CS kept low one half-period), GAP (CS high).
module spi_fram_master #(
    parameter int CLK_DIV = 2,
    parameter int CS_GAP  = 4
) (
    input  logic             clk,
    input  logic             rst,
    spi_fram_master_if.slave bus
);
    typedef enum logic [2:0] {IDLE, SHIFT, HOLD, GAP, DONE} state_t;

    localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_M1 = 8'(CS_GAP - 1);

    state_t      state_r;
    logic [7:0]  cnt_r;
    logic [5:0]  bit_r;
    logic [5:0]  last_r;
    logic [39:0] tx_r;
    logic [7:0]  rx_r;
    logic        we_r;
    logic        wren_r;
    logic [23:0] addr_r;
    logic [7:0]  wdata_r;
    logic        n_ss_r;
    logic        sclk_r;
    logic        mosi_r;
    logic        busy_r;
    logic        done_r;
    logic [7:0]  rdata_r;
    logic [39:0] start_frame_s;
    logic [39:0] wr_frame_s;

    // Frame image, left-justified and MSB first; a WREN frame uses only its top byte.
    function automatic logic [39:0] frame_word(input logic wren, input logic wr,
                                               input logic [23:0] a, input logic [7:0] d);
        if (wren) begin
            return {8'h06, 32'h0000_0000};
        end else if (wr) begin
            return {8'h02, a, d};
        end else begin
            return {8'h03, a, 8'h00};
        end
    endfunction

    assign start_frame_s = frame_word(bus.we, bus.we, bus.addr, bus.wdata);
    assign wr_frame_s    = frame_word(1'b0, 1'b1, addr_r, wdata_r);

    assign bus.n_ss  = n_ss_r;
    assign bus.sclk  = sclk_r;
    assign bus.mosi  = mosi_r;
    assign bus.busy  = busy_r;
    assign bus.done  = done_r;
    assign bus.rdata = rdata_r;

    // Transaction sequencer with all SPI and handshake outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= 8'd0;
            bit_r   <= 6'd0;
            last_r  <= 6'd0;
            tx_r    <= 40'd0;
            rx_r    <= 8'd0;
            we_r    <= 1'b0;
            wren_r  <= 1'b0;
            addr_r  <= 24'd0;
            wdata_r <= 8'd0;
            n_ss_r  <= 1'b1;
            sclk_r  <= 1'b0;
            mosi_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            rdata_r <= 8'd0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE, DONE: begin
                    if (bus.req) begin
                        we_r    <= bus.we;
                        wren_r  <= bus.we;
                        addr_r  <= bus.addr;
                        wdata_r <= bus.wdata;
                        last_r  <= bus.we ? 6'd7 : 6'd39;
                        bit_r   <= 6'd0;
                        cnt_r   <= 8'd0;
                        tx_r    <= {start_frame_s[38:0], 1'b0};
                        mosi_r  <= start_frame_s[39];
                        n_ss_r  <= 1'b0;
                        sclk_r  <= 1'b0;
                        busy_r  <= 1'b1;
                        state_r <= SHIFT;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SHIFT: begin
                    if (cnt_r == DIV_M1) begin
                        cnt_r <= 8'd0;
                        if (!sclk_r) begin
                            sclk_r <= 1'b1;
                            // Bits 32..39 of a read frame are the data byte clocked in from the FRAM.
                            if (!we_r && bit_r >= 6'd32) begin
                                rx_r <= {rx_r[6:0], bus.miso};
                            end
                        end else begin
                            sclk_r <= 1'b0;
                            if (bit_r == last_r) begin
                                bit_r   <= 6'd0;
                                state_r <= HOLD;
                            end else begin
                                bit_r  <= bit_r + 6'd1;
                                mosi_r <= tx_r[39];
                                tx_r   <= {tx_r[38:0], 1'b0};
                            end
                        end
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                HOLD: begin
                    if (cnt_r == DIV_M1) begin
                        cnt_r   <= 8'd0;
                        n_ss_r  <= 1'b1;
                        mosi_r  <= 1'b0;
                        state_r <= GAP;
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                GAP: begin
                    if (cnt_r == GAP_M1) begin
                        cnt_r <= 8'd0;
                        if (wren_r) begin
                            wren_r  <= 1'b0;
                            last_r  <= 6'd39;
                            bit_r   <= 6'd0;
                            tx_r    <= {wr_frame_s[38:0], 1'b0};
                            mosi_r  <= wr_frame_s[39];
                            n_ss_r  <= 1'b0;
                            state_r <= SHIFT;
                        end else begin
                            done_r  <= 1'b1;
                            busy_r  <= 1'b0;
                            state_r <= DONE;
                            if (!we_r) begin
                                rdata_r <= rx_r;
                            end
                        end
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    n_ss_r  <= 1'b1;
                    sclk_r  <= 1'b0;
                    mosi_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end
endmodule
